dmem_responder: RTL

- Memory-side end of the core-to-data-memory request interface (t_core2mem_req) that the pipeline drives from Q103H.
- Accepts word-wide reads/writes with byte enables and holds a synchronous byte-lane RAM.
- Returns read data after a configurable latency.
- Drives a ready/stall signal back to the pipeline when latency exceeds one cycle; with RD_LATENCY=1 the data lands in Q104H.

---
 rtl/dmem_responder_pkg.sv | 39 +++
 rtl/dmem_responder_if.sv | 12 +
 rtl/dmem_responder_array.sv | 29 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    // Core-to-memory request as driven by the pipeline.
    typedef struct packed {
        logic [31:0] wr_data;
        logic [31:0] address;
        logic        wr_en;
        logic        rd_en;
        logic [3:0]  byte_en;
    } t_core2mem_req;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } t_dmem_state;

    // Memory-to-core response.
    typedef struct packed {
        logic [31:0] rd_data;
        logic        rd_valid;
        logic        ready;
    } t_mem2core_rsp;

    // Naturally aligned byte, half and word enables.
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic be_legal(input logic [3:0] be);
        return be inside {BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory bus: request one way, response and error pulses back.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    t_core2mem_req core2mem_req;
    t_mem2core_rsp rsp;
    logic          addr_err;
    logic          misalign_err;

    modport master (output core2mem_req, input rsp, addr_err, misalign_err);
    modport slave  (input core2mem_req, output rsp, addr_err, misalign_err);
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port byte-lane RAM with registered read. The read register is
// reset and only updates on a read strobe, so it holds between reads.
module dmem_array #(
    parameter int WORDS = 1024,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] idx,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);
    logic [3:0][7:0] mem [WORDS];

    // Per-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][i] <= wdata[8*i +: 8];
        end
    end

    // Registered read, captured only on an accepted read.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data-memory port.
// Optional build macro: DMEM_MISALIGN_CHK_EN (reject non-aligned byte_en).
// Read latency is counted here; the RAM itself always reads in one cycle
// and its output register holds the word until the response is delivered.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned MEM_SIZE_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave bus
);
    localparam int          AW       = $clog2(MEM_SIZE_BYTES);
    localparam int          IW       = AW - 2;
    localparam logic [31:0] SIZE32   = 32'(MEM_SIZE_BYTES);
    localparam logic [1:0]  CNT_INIT = 2'(RD_LATENCY - 1);

    t_core2mem_req req;
    t_dmem_state   state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   off;
    logic          in_range, be_bad, ready, acc, acc_wr, acc_rd;
    logic          rd_aerr_q, rd_merr_q, wr_aerr_q, wr_merr_q;
    logic          rd_valid;
    logic [31:0]   ram_q;

    assign req = bus.core2mem_req;

    // Unsigned offset; addresses below the base never wrap into range.
    assign off      = req.address - BASE_ADDR;
    assign in_range = (req.address >= BASE_ADDR) && (off < SIZE32);

`ifdef DMEM_MISALIGN_CHK_EN
    assign be_bad = !be_legal(req.byte_en);
`else
    assign be_bad = 1'b0;
`endif

    assign ready  = (state_q != DMEM_WAIT);
    assign acc    = ready && (req.rd_en || req.wr_en);
    assign acc_wr = acc && req.wr_en;
    assign acc_rd = acc && req.rd_en && !req.wr_en;  // rd+wr acts as write

    dmem_array #(.WORDS(MEM_SIZE_BYTES / 4), .IW(IW)) u_array (
        .clk   (clk),
        .rst   (rst),
        .idx   (off[AW-1:2]),
        .we    ((acc_wr && in_range && !be_bad) ? req.byte_en : 4'b0000),
        .wdata (req.wr_data),
        .re    (acc_rd && in_range && !be_bad),
        .rdata (ram_q)
    );

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: single-cycle reads go straight to RESP, longer ones wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMEM_IDLE, DMEM_RESP: begin
                state_d = DMEM_IDLE;
                if (acc_rd) begin
                    if (RD_LATENCY == 1) begin
                        state_d = DMEM_RESP;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = DMEM_RESP;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Error flags: read flags ride along until the response, write flags
    // pulse the cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_aerr_q <= 1'b0;
            rd_merr_q <= 1'b0;
            wr_aerr_q <= 1'b0;
            wr_merr_q <= 1'b0;
        end else begin
            if (acc_rd) begin
                rd_aerr_q <= !in_range;
                rd_merr_q <= be_bad;
            end
            wr_aerr_q <= acc_wr && !in_range;
            wr_merr_q <= acc_wr && be_bad;
        end
    end

    assign rd_valid         = (state_q == DMEM_RESP);
    assign bus.rsp.rd_data  = (rd_aerr_q || rd_merr_q) ? 32'h0 : ram_q;
    assign bus.rsp.rd_valid = rd_valid;
    assign bus.rsp.ready    = ready;
    assign bus.addr_err     = wr_aerr_q || (rd_valid && rd_aerr_q);
    assign bus.misalign_err = wr_merr_q || (rd_valid && rd_merr_q);
endmodule
